// File: rtl/dmem_lsu.sv
// Word-organised data memory with a RISC-V style load/store front end.
// One request at a time; the response appears RD_LAT cycles after acceptance.
module dmem_lsu #(
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned RD_LAT        = 1,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_words [DEPTH];
  logic [29:0] widx;
  logic [1:0]  lane;
  logic [AW-1:0] midx;
  logic        accept, range_err, size_err, req_err, wr_en;
  logic [3:0]  be;
  logic [31:0] wword, rword, rshift, load_val, wmerge;

  assign req_ready = (state_q == StIdle) && !reset;
  assign accept    = req_valid && req_ready;
  assign widx      = req_addr[31:2];
  assign lane      = req_addr[1:0];
  assign midx      = widx[AW-1:0];
  assign range_err = ({2'b00, widx} >= DEPTH);
  assign req_err   = range_err || size_err;
  assign wr_en     = accept && req_we && !req_err;
  assign rword     = mem_words[midx];
  assign rshift    = rword >> {lane, 3'b000};

  // Size decode: byte enables, lane-replicated store data and alignment faults.
  always_comb begin
    size_err = 1'b0;
    be       = 4'b0000;
    wword    = 32'h0;
    case (req_funct3)
      3'd0, 3'd4: begin
        be    = 4'b0001 << lane;
        wword = {4{req_wdata[7:0]}};
      end
      3'd1, 3'd5: begin
        size_err = lane[0];
        be       = 4'b0011 << lane;
        wword    = {2{req_wdata[15:0]}};
      end
      3'd2: begin
        size_err = (lane != 2'b00);
        be       = 4'b1111;
        wword    = req_wdata;
      end
      default: size_err = 1'b1;
    endcase
    if (req_we && (req_funct3 >= 3'd3)) size_err = 1'b1;
  end

  always_comb begin
    load_val = 32'h0;
    case (req_funct3)
      3'd0:    load_val = {{24{rshift[7]}}, rshift[7:0]};
      3'd1:    load_val = {{16{rshift[15]}}, rshift[15:0]};
      3'd2:    load_val = rword;
      3'd4:    load_val = {24'h0, rshift[7:0]};
      3'd5:    load_val = {16'h0, rshift[15:0]};
      default: load_val = 32'h0;
    endcase
  end

  always_comb begin
    wmerge = rword;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) wmerge[8*b +: 8] = wword[8*b +: 8];
    end
  end

  // One register per word so reset preload and store commit share a single process per entry.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [31:0] word_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        if (INIT_ON_RESET != 0) word_q <= 32'(i);
      end else if (wr_en && (midx == AW'(i))) begin
        word_q <= wmerge;
      end
    end
    assign mem_words[i] = word_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          err_d   = req_err;
          rdata_d = (req_we || req_err) ? 32'h0 : load_val;
          if (RD_LAT > 1) begin
            state_d = StWait;
            cnt_d   = 2'(RD_LAT - 2);
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) state_d = StResp;
        else               cnt_d   = 2'(cnt_q - 2'd1);
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_valid = (state_q == StResp);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid && err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: one instance with RD_LAT=1, one with RD_LAT=3.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [32:0] sb0 [$];
  logic [32:0] sb1 [$];
  logic [32:0] e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_lsu #(.DEPTH(256), .RD_LAT(1), .INIT_ON_RESET(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0])
  );

  dmem_lsu #(.DEPTH(256), .RD_LAT(3), .INIT_ON_RESET(1)) u_lat3 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid[0]) begin
        if (sb0.size() == 0) check("unexpected_resp_lat1", 32'd1, 32'd0);
        else begin
          e0 = sb0.pop_front();
          check("rdata_lat1", resp_rdata[0], e0[31:0]);
          check("err_lat1", 32'(resp_err[0]), 32'(e0[32]));
        end
      end else begin
        check("idle_out_lat1", resp_rdata[0] | 32'(resp_err[0]), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid[1]) begin
        if (sb1.size() == 0) check("unexpected_resp_lat3", 32'd1, 32'd0);
        else begin
          e1 = sb1.pop_front();
          check("rdata_lat3", resp_rdata[1], e1[31:0]);
          check("err_lat3", 32'(resp_err[1]), 32'(e1[32]));
        end
      end else begin
        check("idle_out_lat3", resp_rdata[1] | 32'(resp_err[1]), 32'd0);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge of the response cycle.
  task automatic do_req(input int sel, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
    int acc;
    bit got;
    if (sel == 0) sb0.push_back({exp_err, exp_rd});
    else          sb1.push_back({exp_err, exp_rd});
    req_valid[sel]  = 1'b1;
    req_we[sel]     = we;
    req_funct3[sel] = f3;
    req_addr[sel]   = addr;
    req_wdata[sel]  = wdata;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (req_ready[sel]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid[sel] = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (resp_valid[sel]) begin
        check("latency", 32'(cyc - acc + 1), (sel == 0) ? 32'd1 : 32'd3);
        got = 1'b1;
        break;
      end
    end
    if (!got) check("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      req_we[i]     = 1'b0;
      req_funct3[i] = 3'd0;
      req_addr[i]   = 32'h0;
      req_wdata[i]  = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset_lat1", 32'(req_ready[0]), 32'd0);
    check("ready_in_reset_lat3", 32'(req_ready[1]), 32'd0);
    check("valid_in_reset", 32'(resp_valid[0]), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready[0]), 32'd1);

    // RD_LAT=1: sizes, sign handling, faults and store-to-load ordering.
    do_req(0, 1'b0, 3'd2, 32'h10, 32'h0, 32'h0000_0004, 1'b0);
    do_req(0, 1'b1, 3'd0, 32'h11, 32'h1234_56AB, 32'h0, 1'b0);
    do_req(0, 1'b0, 3'd2, 32'h10, 32'h0, 32'h0000_AB04, 1'b0);
    do_req(0, 1'b0, 3'd0, 32'h11, 32'h0, 32'hFFFF_FFAB, 1'b0);
    do_req(0, 1'b0, 3'd4, 32'h11, 32'h0, 32'h0000_00AB, 1'b0);
    do_req(0, 1'b1, 3'd1, 32'h22, 32'h0000_8001, 32'h0, 1'b0);
    do_req(0, 1'b0, 3'd1, 32'h22, 32'h0, 32'hFFFF_8001, 1'b0);
    do_req(0, 1'b0, 3'd2, 32'h20, 32'h0, 32'h8001_0008, 1'b0);
    do_req(0, 1'b0, 3'd5, 32'h22, 32'h0, 32'h0000_8001, 1'b0);
    do_req(0, 1'b0, 3'd0, 32'h23, 32'h0, 32'hFFFF_FF80, 1'b0);
    do_req(0, 1'b0, 3'd4, 32'h23, 32'h0, 32'h0000_0080, 1'b0);
    do_req(0, 1'b0, 3'd1, 32'h13, 32'h0, 32'h0, 1'b1);
    do_req(0, 1'b1, 3'd2, 32'h06, 32'hFFFF_FFFF, 32'h0, 1'b1);
    do_req(0, 1'b0, 3'd2, 32'h04, 32'h0, 32'h0000_0001, 1'b0);
    do_req(0, 1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 1'b1);
    do_req(0, 1'b0, 3'd3, 32'h00, 32'h0, 32'h0, 1'b1);
    do_req(0, 1'b1, 3'd4, 32'h30, 32'h5555_5555, 32'h0, 1'b1);
    do_req(0, 1'b0, 3'd2, 32'h30, 32'h0, 32'h0000_000C, 1'b0);
    do_req(0, 1'b1, 3'd2, 32'h3FC, 32'hCAFE_F00D, 32'h0, 1'b0);
    do_req(0, 1'b0, 3'd2, 32'h3FC, 32'h0, 32'hCAFE_F00D, 1'b0);

    // RD_LAT=3: back-to-back requests with req_valid held high.
    sb1.push_back({1'b0, 32'd2});
    sb1.push_back({1'b0, 32'd2});
    req_valid[1]  = 1'b1;
    req_we[1]     = 1'b0;
    req_funct3[1] = 3'd2;
    req_addr[1]   = 32'h8;
    check("b2b_ready_first", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("b2b_ready_low", 32'(req_ready[1]), 32'd0);
      check("b2b_resp_valid", 32'(resp_valid[1]), (k == 2) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("b2b_ready_back", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    repeat (4) @(negedge clk);

    // RD_LAT=3: reset one cycle after a load accept discards it and re-preloads memory.
    do_req(1, 1'b1, 3'd2, 32'h14, 32'hDEAD_BEEF, 32'h0, 1'b0);
    do_req(1, 1'b0, 3'd2, 32'h14, 32'h0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    req_valid[1]  = 1'b1;
    req_we[1]     = 1'b0;
    req_funct3[1] = 3'd2;
    req_addr[1]   = 32'h14;
    check("pre_reset_ready", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("ready_in_mid_reset", 32'(req_ready[1]), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_mid_reset", 32'(req_ready[1]), 32'd1);
    repeat (5) @(negedge clk);
    do_req(1, 1'b0, 3'd2, 32'h14, 32'h0, 32'h0000_0005, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained_lat1", 32'(sb0.size()), 32'd0);
    check("sb_drained_lat3", 32'(sb1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
